// File: rtl/nested_loop_counter_if.sv
// Control and status bundle of the nested loop-index counter.
// The master side (controller) drives clear, advance, mode and bounds;
// the slave side (the counter) returns indices, carries and done flags.
interface nested_loop_counter_if #(
    parameter int WIDTH  = 5,
    parameter int LEVELS = 3
);

    logic                      clr;
    logic                      count_en;
    logic                      mode;
    logic [LEVELS*WIDTH-1:0]   bounds;
    logic [LEVELS*WIDTH-1:0]   count;
    logic [LEVELS-1:0]         level_carry;
    logic                      done;
    logic                      done_pulse;

    modport master (
        output clr,
        output count_en,
        output mode,
        output bounds,
        input  count,
        input  level_carry,
        input  done,
        input  done_pulse
    );

    modport slave (
        input  clr,
        input  count_en,
        input  mode,
        input  bounds,
        output count,
        output level_carry,
        output done,
        output done_pulse
    );

endinterface

// File: rtl/nested_loop_counter.sv
// Multi-level cascaded loop-index counter with per-level programmable trip
// counts. Level 0 is the fastest index. Saturate mode stops on a sticky done
// after one full nest; wrap mode runs continuously and only pulses done_pulse.
module nested_loop_counter #(
    parameter int WIDTH  = 5,
    parameter int LEVELS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    nested_loop_counter_if.slave bus
);

    logic [WIDTH-1:0]  cnt_q [LEVELS];
    logic [WIDTH-1:0]  cnt_d [LEVELS];
    logic              done_q;
    logic              done_d;
    logic              donePulse_q;
    logic              donePulse_d;
    logic [LEVELS-1:0] carry_w;
    logic              adv_w;
    logic              terminal_w;

    // Carry chain and next-state: a level steps when every faster level is
    // at its terminal index; ">=" lets a lowered bound force a wrap.
    always_comb begin
        logic             chain;
        logic [WIDTH-1:0] effBound;
        logic [WIDTH-1:0] boundM1;
        logic             isLast;

        adv_w    = bus.count_en & ~done_q & ~bus.clr;
        chain    = adv_w;
        carry_w  = '0;
        effBound = '0;
        boundM1  = '0;
        isLast   = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            effBound = bus.bounds[i*WIDTH +: WIDTH];
            if (effBound == '0) begin
                effBound = WIDTH'(1);
            end
            boundM1 = effBound - WIDTH'(1);
            isLast  = (cnt_q[i] >= boundM1);
            cnt_d[i] = cnt_q[i];
            if (bus.clr) begin
                cnt_d[i] = '0;
            end else if (chain) begin
                cnt_d[i] = isLast ? '0 : (cnt_q[i] + WIDTH'(1));
            end
            chain      = chain & isLast;
            carry_w[i] = chain;
        end

        terminal_w = carry_w[LEVELS-1];

        done_d = done_q;
        if (bus.clr) begin
            done_d = 1'b0;
        end else if (terminal_w && !bus.mode) begin
            done_d = 1'b1;
        end

        donePulse_d = terminal_w & ~bus.clr;
    end

    // State registers; reset clears every index and both done flags at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEVELS; i++) begin
                cnt_q[i] <= '0;
            end
            done_q      <= 1'b0;
            donePulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            done_q      <= done_d;
            donePulse_q <= donePulse_d;
        end
    end

    // Pack the per-level indices onto the flat count bus.
    always_comb begin
        bus.count = '0;
        for (int i = 0; i < LEVELS; i++) begin
            bus.count[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign bus.level_carry = carry_w;
    assign bus.done        = done_q;
    assign bus.done_pulse  = donePulse_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Scoreboard bench for nested_loop_counter (WIDTH=5, LEVELS=3).
module tb_nested_loop_counter;

    localparam int W = 5;
    localparam int L = 3;

    typedef struct {
        logic [L*W-1:0] count;
        logic           done;
        logic           pulse;
    } expT;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    expT  scoreQ[$];

    int   mCnt [L];
    logic mDone;
    logic mPulse;

    nested_loop_counter_if #(.WIDTH(W), .LEVELS(L)) bus ();

    nested_loop_counter #(.WIDTH(W), .LEVELS(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] packB(input int v);
        logic [W-1:0] r;
        r = v[W-1:0];
        return r;
    endfunction

    task automatic setBounds(input int b0, input int b1, input int b2);
        bus.bounds = {packB(b2), packB(b1), packB(b0)};
    endtask

    task automatic resetModel();
        for (int i = 0; i < L; i++) mCnt[i] = 0;
        mDone  = 1'b0;
        mPulse = 1'b0;
    endtask

    // Ripple-increment reference model; returns the carries of this cycle.
    task automatic modelStep(input logic en, input logic clrIn, output logic [L-1:0] expCarry);
        int  eff;
        logic carryIn;
        expCarry = '0;
        if (clrIn) begin
            resetModel();
        end else if (en && !mDone) begin
            carryIn = 1'b1;
            for (int i = 0; i < L; i++) begin
                eff = int'(bus.bounds[i*W +: W]);
                if (eff == 0) eff = 1;
                if (carryIn) begin
                    if (mCnt[i] + 1 >= eff) begin
                        mCnt[i]     = 0;
                        expCarry[i] = 1'b1;
                    end else begin
                        mCnt[i] = mCnt[i] + 1;
                        carryIn = 1'b0;
                    end
                end
            end
            mPulse = expCarry[L-1];
            if (expCarry[L-1] && !bus.mode) mDone = 1'b1;
        end else begin
            mPulse = 1'b0;
        end
    endtask

    task automatic pushExpected();
        expT e;
        for (int i = 0; i < L; i++) e.count[i*W +: W] = packB(mCnt[i]);
        e.done  = mDone;
        e.pulse = mPulse;
        scoreQ.push_back(e);
    endtask

    // One clocked cycle: drive, check combinational carry, then the
    // registered outputs after the edge against the scoreboard entry.
    task automatic applyStimulus(input logic en, input logic clrIn);
        logic [L-1:0] expCarry;
        expT          e;
        @(negedge clk);
        bus.count_en = en;
        bus.clr      = clrIn;
        #1;
        modelStep(en, clrIn, expCarry);
        pushExpected();
        testsRun++;
        if (bus.level_carry !== expCarry) begin
            testsFailed++;
            $display("[TB] FAIL level_carry: got %b expected %b", bus.level_carry, expCarry);
        end
        @(posedge clk);
        #1;
        bus.count_en = 1'b0;
        bus.clr      = 1'b0;
        testsRun++;
        if (scoreQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: queue empty");
        end else begin
            e = scoreQ.pop_front();
            if (bus.count !== e.count || bus.done !== e.done || bus.done_pulse !== e.pulse) begin
                testsFailed++;
                $display("[TB] FAIL state: got count=%h done=%b pulse=%b expected count=%h done=%b pulse=%b",
                         bus.count, bus.done, bus.done_pulse, e.count, e.done, e.pulse);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clr = 1'b0;
        bus.count_en = 1'b0;
        bus.mode = 1'b0;
        setBounds(3, 2, 2);
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (bus.count !== '0 || bus.done !== 1'b0 || bus.done_pulse !== 1'b0 || bus.level_carry !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset: count=%h done=%b pulse=%b carry=%b expected all 0",
                     bus.count, bus.done, bus.done_pulse, bus.level_carry);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        int doneStep;
        doneStep = -1;
        bus.mode = 1'b0;
        setBounds(3, 2, 2);
        applyStimulus(1'b0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (doneStep < 0 && bus.done === 1'b1) doneStep = k;
        end
        testsRun++;
        if (doneStep !== 12) begin
            testsFailed++;
            $display("[TB] FAIL saturate_done_step: got %0d expected 12", doneStep);
        end
        testsRun++;
        if (bus.count !== '0 || bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL saturate_hold: got count=%h done=%b expected 0 and 1", bus.count, bus.done);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        applyStimulus(1'b0, 1'b1);
        bus.mode = 1'b1;
        setBounds(2, 2, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (bus.done_pulse === 1'b1) pulses++;
        end
        testsRun++;
        if (pulses !== 2 || bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_pulses: got %0d pulses done=%b expected 2 and 0", pulses, bus.done);
        end
    endtask

    task automatic test_bound_zero();
        int doneStep;
        doneStep = -1;
        bus.mode = 1'b0;
        setBounds(2, 0, 3);
        applyStimulus(1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (doneStep < 0 && bus.done === 1'b1) doneStep = k;
        end
        testsRun++;
        if (doneStep !== 6) begin
            testsFailed++;
            $display("[TB] FAIL bound_zero_done_step: got %0d expected 6", doneStep);
        end
    endtask

    task automatic test_bound_lowered();
        bus.mode = 1'b0;
        setBounds(8, 1, 1);
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0);
        testsRun++;
        if (bus.count[W-1:0] !== 5'd5) begin
            testsFailed++;
            $display("[TB] FAIL lowered_pre: got cnt0=%0d expected 5", bus.count[W-1:0]);
        end
        setBounds(3, 1, 1);
        applyStimulus(1'b1, 1'b0);
        testsRun++;
        if (bus.count !== '0 || bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lowered_wrap: got count=%h done=%b expected 0 and 1", bus.count, bus.done);
        end
    endtask

    task automatic test_clr_priority();
        bus.mode = 1'b0;
        setBounds(3, 2, 2);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b0);
        testsRun++;
        if (bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clr_pre_done: got done=%b expected 1", bus.done);
        end
        bus.mode = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_done: got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_async_reset();
        bus.mode = 1'b0;
        setBounds(3, 2, 2);
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
        testsRun++;
        if (bus.count !== {5'd0, 5'd1, 5'd1}) begin
            testsFailed++;
            $display("[TB] FAIL async_pre: got count=%h expected 0021", bus.count);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (bus.count !== '0 || bus.done !== 1'b0 || bus.done_pulse !== 1'b0 || bus.level_carry !== '0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: count=%h done=%b pulse=%b carry=%b expected all 0",
                     bus.count, bus.done, bus.done_pulse, bus.level_carry);
        end
        #1;
        rst = 1'b0;
        resetModel();
        applyStimulus(1'b1, 1'b0);
        testsRun++;
        if (bus.count[W-1:0] !== 5'd1) begin
            testsFailed++;
            $display("[TB] FAIL async_first_step: got cnt0=%0d expected 1", bus.count[W-1:0]);
        end
    endtask

    task automatic checkOutput();
        testsRun++;
        if (scoreQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", scoreQ.size());
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_saturate();
        test_wrap();
        test_bound_zero();
        test_bound_lowered();
        test_clr_priority();
        test_async_reset();
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/nested_loop_counter.md
# nested_loop_counter

Multi-level loop-index counter for the convolution datapath: `LEVELS` cascaded counters with per-level programmable bounds. Level 0 is the fastest index, e.g. filter tap; higher levels are row, channel, and so on. It replaces single-bound finish counters in the address generator and control FSM. It supports a sticky-done saturate mode for one-shot passes and a wrap mode for continuous streaming, with per-level carry outputs for loop-boundary events.

## Interface

**Parameters**
- `WIDTH`, default 5: bit width of each level's counter and bound.
- `LEVELS`, default 3: number of nested levels (≥1).

**Ports**
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `clr`, in, 1: synchronous clear; priority over `count_en`.
- `count_en`, in, 1: advance request, one step per cycle when high.
- `mode`, in, 1: 0 = saturate (sticky done), 1 = wrap (free-running).
- `bounds`, in, `LEVELS*WIDTH`: trip count of level i in bits `[i*WIDTH +: WIDTH]`; 0 is treated as 1.
- `count`, out, `LEVELS*WIDTH`: current index of level i in bits `[i*WIDTH +: WIDTH]`; registered.
- `level_carry`, out, `LEVELS`: bit i high when level i wraps on this edge; combinational.
- `done`, out, 1: saturate mode only; registered; sticky until `clr` or `rst`.
- `done_pulse`, out, 1: one-cycle registered pulse after any full-nest completion, in either mode.

## Operation

- **Per-level terminal flag:** `last_i = (cnt_i >= bound_i - 1)`, or `bound_i <= 1`.
  - Use `>=`, not `==`, so that a bound lowered below the current index forces a wrap on the next advance.
- **Advance:** `adv = count_en & ~done & ~clr`.
- **Carry:** `level_carry[i] = adv & last_0 & ... & last_i`.
- **Per-level update when `adv`:**
  - Level 0 always steps.
  - Level i>0 steps when `level_carry[i-1]`.
  - Stepping a level with `last_i` loads 0; otherwise it increments by 1.
- **Terminal advance:** `level_carry[LEVELS-1]` is high.
  - All counters load 0.
  - `done_pulse` is 1 next cycle.
  - If `mode` = 0, `done` is set.
  - If `mode` = 1, `done` is unaffected (stays 0).
- **While `done` = 1:** `count_en` is ignored; counters hold at 0; `level_carry` = 0.
- **`clr`:** all counters, `done` and `done_pulse` go to 0 next edge, regardless of `count_en`.
- **Reset values:** `count` all 0, `done` 0, `done_pulse` 0, `level_carry` 0.
- **Arithmetic:** unsigned, `WIDTH` bits. `bound - 1` is computed in `WIDTH` bits after bound-0-to-1 substitution, so there is no underflow.
  - Maximum trip per level is `2^WIDTH - 1`.
  - Total nest length is the product of effective bounds.
- **`mode` changes:** sampled every cycle; changing it mid-nest takes effect at the next terminal advance.
  - Clearing `mode` to 0 does not retroactively set `done`.
  - Setting `mode` to 1 while `done` = 1 does not clear `done`; only `clr` or `rst` clears it.

## Timing

- Latency from `count_en` high at edge k to the updated `count`: visible after edge k (1 cycle).
- `level_carry` is combinational from `count`, `bounds`, `count_en`, `clr` and `done`, valid in the same cycle as the advance it describes.
- `done` and `done_pulse` rise 1 cycle after the terminal-advance edge's inputs are sampled, i.e. both are visible after the same edge on which the counters return to 0.
- Back-to-back `count_en` gives one step per cycle, with no bubbles at level boundaries or in wrap mode.
- Asynchronous `rst` mid-nest zeros all state immediately. The first step after deassertion starts from index 0.
- `clr` and `count_en` in the same cycle: the clear wins, `level_carry` = 0, and no pulse is generated.

## Test plan

- **Saturate, bounds (3,2,2), `count_en` held high:** 12 steps.
  - Level-0 sequence is 0,1,2,0,1,2…
  - `level_carry[0]` every 3rd step; `level_carry[1]` every 6th; `level_carry[2]` on the 12th step.
  - `done` and `done_pulse` go high after step 12.
  - Further `count_en` leaves `count` = 0 and `done` = 1.
- **Wrap, bounds (2,2,1):** 8 steps. `done_pulse` goes high after steps 4 and 8 and `done` stays 0. The sequence restarts at 0 with no stall.
- **Bound 0 on level 1, bounds (2,0,3), saturate:**
  - Level 1 stays 0 and carries whenever level 0 carries.
  - `done` goes high after 6 steps.
- **Bound lowered mid-count:**
  - Bounds (8,1,1), advance to `cnt0` = 5, then set bound0 = 3.
  - The next step wraps `cnt0` to 0 with `level_carry[0]` = 1, and `done` = 1 (saturate).
- **`clr` priority:**
  - At `cnt0` = 2, assert `clr` and `count_en` together. Next cycle all counts are 0, no carry, no `done_pulse`.
  - With `done` = 1, `clr` clears `done`.
- **Asynchronous reset mid-nest:**
  - Pulse `rst` between clock edges at count (1,1,0). All outputs go to 0 without waiting for a clock edge.
  - After release, the first enabled step gives `cnt0` = 1.
